servo_pulse_decoder: RTL
========================

SERVO_PULSE_DECODER -- requirements
Module: servo_pulse_decoder

Interface
REQ-001 Parameter TICK_DIV, default 488, clk25mhz cycles per duty-code LSB (1/1024 of a 20 ms frame).
REQ-002 Parameter TIMEOUT, default 625000, cycles without a completed pulse before declaring loss (25 ms).
REQ-003 Parameter LOW_THRESH, default 64, codes below this classify as position LOW.
REQ-004 Parameter HIGH_THRESH, default 90, codes above this classify as position HIGH.
REQ-005 clk25mhz  input  1  sole clock, 25 MHz, all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 servoSignal  input  1  asynchronous servo PWM input, pulse-high-active.
REQ-008 duty_code  output  10  last measured pulse width in duty-code units, same scale as the servo driver's duty_cycle_input.
REQ-009 duty_valid  output  1  one-cycle strobe when duty_code updates.
REQ-010 position  output  2  classification of duty_code: 0 center, 1 LOW, 2 HIGH, 3 never driven.
REQ-011 signal_lost  output  1  level; high while no valid pulse seen within TIMEOUT.

Function
REQ-012 servoSignal SHALL pass through a 2-flop synchronizer; all edges are detected on the synchronized signal.
REQ-013 FSM states: SEEK, ARMED, HIGH.
REQ-014 SEEK: wait for synchronized input low, then go to ARMED; prevents measuring a partial pulse after reset or loss.
REQ-015 ARMED: on rising edge go to HIGH, clear tick counter and code accumulator.
REQ-016 HIGH: tick counter counts 0..TICK_DIV-1; on wrap accumulator increments, saturating at 1023.
REQ-017 HIGH, falling edge: duty_code <= accumulator (floor(high_cycles/TICK_DIV)), duty_valid pulses 1 cycle, position updates same cycle, state -> ARMED.
REQ-018 Latency: duty_valid SHALL assert exactly 3 clocks after the first clk25mhz edge sampling servoSignal low (filter off).
REQ-019 Frame timer counts cycles since the last duty_valid (or since reset); reaching TIMEOUT sets signal_lost, state -> SEEK, duty_code held.
REQ-020 Frame timer saturates at TIMEOUT; it does not wrap.
REQ-021 signal_lost clears on the cycle duty_valid next asserts.
REQ-022 Input stuck high in HIGH: accumulator saturates at 1023, timeout still fires per REQ-019, no duty_valid issued.
REQ-023 Pulse shorter than TICK_DIV cycles: duty_code = 0, duty_valid still asserted, position = LOW.
REQ-024 Timeout and falling edge in the same cycle: the measurement wins (duty_valid, signal_lost cleared, state ARMED).
REQ-025 position: code < LOW_THRESH -> 1; code > HIGH_THRESH -> 2; else 0.

Reset
REQ-026 On reset: state SEEK, duty_code 0, duty_valid 0, position 3, signal_lost 1, all counters and synchronizer flops 0.
REQ-027 Reset asserted mid-pulse SHALL discard the measurement; no duty_valid for that pulse.

Configuration
REQ-028 Macro SERVO_DECODE_GLITCH_FILTER_EN defined: synchronized input passes a 4-cycle stability filter (level changes only after 4 consecutive equal samples); latency REQ-018 becomes 7 clocks; high pulses shorter than 4 cycles are ignored.
REQ-029 Macro undefined: no filter, latency 3 clocks, any synchronized transition is an edge.

Verification
REQ-030 Reset, then 1.5 ms pulse (37500 cycles high) in 20 ms frame -> duty_valid once per frame, duty_code 76, position 0, signal_lost 0 after first pulse.
REQ-031 1.0 ms pulse (25000 cycles) -> duty_code 51, position 1; 2.0 ms pulse (50000 cycles) -> duty_code 102, position 2.
REQ-032 Release reset with servoSignal already high for 10000 cycles, then normal 1.5 ms frames -> first partial pulse yields no duty_valid; next pulse gives 76.
REQ-033 Input held low 700000 cycles after a valid pulse -> signal_lost rises exactly 625000 cycles after last duty_valid, duty_code stays 76; next pulse clears it.
REQ-034 Reset asserted 20000 cycles into a pulse, released 10 cycles later while input still high -> no duty_valid until the following full pulse.
REQ-035 With SERVO_DECODE_GLITCH_FILTER_EN: 2-cycle high glitches between frames -> no duty_valid; 1.5 ms pulse -> 76 with 7-cycle latency.

Source files
------------

// File: rtl/servo_pulse_decoder.sv
// servo_pulse_decoder
//   Measures the high time of a servo PWM input and reports it as a 10-bit duty
//   code on the same scale as the servo driver (1 LSB = TICK_DIV clocks). The
//   code is also classified as center/LOW/HIGH, and loss of signal is flagged
//   when no pulse completes within TIMEOUT clocks.
//
// Ports
//   clk25mhz     in   sole clock, rising edge
//   reset        in   synchronous, active-high
//   servoSignal  in   asynchronous PWM input, high-active pulse
//   duty_code    out  [9:0] last measured width, floor(high_cycles / TICK_DIV)
//   duty_valid   out  one-cycle strobe when duty_code updates
//   position     out  [1:0] 0 center, 1 LOW, 2 HIGH, 3 nothing measured yet
//   signal_lost  out  high while no pulse has completed within TIMEOUT clocks
//
// Build option
//   SERVO_DECODE_GLITCH_FILTER_EN: adds a 4-sample stability filter after the
//   synchronizer. Pulses shorter than 4 clocks are ignored and the fall-to-strobe
//   latency grows from 3 to 7 clocks.
module servo_pulse_decoder #(
    parameter int unsigned TICK_DIV    = 488,
    parameter int unsigned TIMEOUT     = 625000,
    parameter int unsigned LOW_THRESH  = 64,
    parameter int unsigned HIGH_THRESH = 90
) (
    input  logic       clk25mhz,
    input  logic       reset,
    input  logic       servoSignal,
    output logic [9:0] duty_code,
    output logic       duty_valid,
    output logic [1:0] position,
    output logic       signal_lost
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TickLast  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FrameMax  = FW'(TIMEOUT);
    localparam logic [FW-1:0] FrameLast = FW'(TIMEOUT - 1);
    localparam logic [9:0]    LowThr    = 10'(LOW_THRESH);
    localparam logic [9:0]    HighThr   = 10'(HIGH_THRESH);
    // Consecutive low samples needed before arming; must exceed the pipeline
    // depth so zeroed flops right after reset are never mistaken for a real low.
    localparam logic [3:0]    SeekLast  = 4'd15;

    typedef enum logic [1:0] {StSeek, StArmed, StHigh} state_e;

    state_e        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic          lvl_q, lvl_d;
    logic          prev_q;
    logic [3:0]    seek_q, seek_d;
    logic [TW-1:0] tick_q, tick_d, tick_inc;
    logic [9:0]    acc_q, acc_d, acc_inc;
    logic [FW-1:0] frame_q, frame_d;
    logic [9:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic [1:0]    pos_q, pos_d;
    logic          lost_q, lost_d;
    logic          rise, fall, measure;

`ifdef SERVO_DECODE_GLITCH_FILTER_EN
    logic [3:0] hist_q, hist_d;

    // Level follows the input only once the last four samples agree.
    always_comb begin
        hist_d = {hist_q[2:0], sync2_q};
        lvl_d  = lvl_q;
        if (&hist_q) begin
            lvl_d = 1'b1;
        end else if (~|hist_q) begin
            lvl_d = 1'b0;
        end
    end
`else
    always_comb begin
        lvl_d = sync2_q;
    end
`endif

    assign rise    = lvl_q & ~prev_q;
    assign fall    = ~lvl_q & prev_q;
    assign measure = (state_q == StHigh) && fall;

    function automatic logic [1:0] classify(input logic [9:0] code);
        if (code < LowThr) begin
            return 2'd1;
        end else if (code > HighThr) begin
            return 2'd2;
        end else begin
            return 2'd0;
        end
    endfunction

    // Tick/code accumulation for one cycle spent in StHigh.
    always_comb begin
        if (tick_q == TickLast) begin
            tick_inc = '0;
            acc_inc  = (acc_q == 10'h3FF) ? acc_q : acc_q + 10'd1;
        end else begin
            tick_inc = tick_q + TW'(1);
            acc_inc  = acc_q;
        end
    end

    always_comb begin
        state_d = state_q;
        seek_d  = seek_q;
        tick_d  = tick_q;
        acc_d   = acc_q;
        code_d  = code_q;
        valid_d = 1'b0;
        pos_d   = pos_q;
        lost_d  = lost_q;
        frame_d = (frame_q == FrameMax) ? frame_q : frame_q + FW'(1);

        case (state_q)
            StSeek: begin
                if (!lvl_q) begin
                    if (seek_q == SeekLast) begin
                        state_d = StArmed;
                        seek_d  = '0;
                    end else begin
                        seek_d = seek_q + 4'd1;
                    end
                end else begin
                    seek_d = '0;
                end
            end
            StArmed: begin
                if (rise) begin
                    state_d = StHigh;
                    tick_d  = '0;
                    acc_d   = '0;
                end
            end
            StHigh: begin
                tick_d = tick_inc;
                acc_d  = acc_inc;
                if (fall) begin
                    // The falling cycle itself counts as a high cycle.
                    code_d  = acc_inc;
                    pos_d   = classify(acc_inc);
                    valid_d = 1'b1;
                    lost_d  = 1'b0;
                    frame_d = '0;
                    state_d = StArmed;
                end
            end
            default: state_d = StSeek;
        endcase

        // Timeout fires once, on the step to TIMEOUT; a coincident measurement wins.
        if (!measure && (frame_q == FrameLast)) begin
            lost_d  = 1'b1;
            state_d = StSeek;
            seek_d  = '0;
        end
    end

    always_ff @(posedge clk25mhz) begin
        if (reset) begin
            state_q <= StSeek;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            prev_q  <= 1'b0;
            seek_q  <= '0;
            tick_q  <= '0;
            acc_q   <= '0;
            frame_q <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            pos_q   <= 2'd3;
            lost_q  <= 1'b1;
`ifdef SERVO_DECODE_GLITCH_FILTER_EN
            hist_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= servoSignal;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
            seek_q  <= seek_d;
            tick_q  <= tick_d;
            acc_q   <= acc_d;
            frame_q <= frame_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            pos_q   <= pos_d;
            lost_q  <= lost_d;
`ifdef SERVO_DECODE_GLITCH_FILTER_EN
            hist_q  <= hist_d;
`endif
        end
    end

    assign duty_code   = code_q;
    assign duty_valid  = valid_q;
    assign position    = pos_q;
    assign signal_lost = lost_q;

endmodule
